imem_loader: RTL and testbench

Writer side of the instruction memory. Receives a program as a stream of bytes over a valid/ready handshake and assembles each group of 4 bytes, little-endian, into a 32-bit instruction word. Issues one write per word into the instruction memory's write port at consecutive word addresses starting at 0. Sits between the boot/UART byte source and the instruction memory, which the core reads through its addr/dout port.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 110 +++++++++++
 tb/tb_imem_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    localparam int POS      = 1024;
    localparam int NUM_BITS = 32;
    localparam int ADDR_W   = $clog2(POS);

    typedef logic [ADDR_W-1:0]   iaddr_t;
    typedef logic [NUM_BITS-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // Counter width that stays legal when only one slot exists.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects bytes little-endian into one instruction word.
// word_next is the assembly register with the byte currently on byte_data
// merged into its slot, so the owner can capture a complete word on the
// same edge that accepts the last byte.
module byte_packer
    import imem_pkg::*;
#(
    parameter int num_bits = NUM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                fire,
    input  logic [7:0]          byte_data,
    output logic [num_bits-1:0] word_next,
    output logic                word_full
);

    localparam int NB = num_bits / 8;
    localparam int CW = cnt_width(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [CW-1:0]       cnt;
    logic [num_bits-1:0] asm_q;

    // Byte slot counter and assembly register; wraps to slot 0 after the last byte.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= '0;
            asm_q <= '0;
        end else if (fire) begin
            asm_q <= word_next;
            cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Merge the incoming byte into its little-endian slot.
    always_comb begin
        word_next                 = asm_q;
        word_next[8*cnt +: 8]     = byte_data;
        word_full                 = fire && (cnt == LAST);
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory writer.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
// byte_ready is high only in RECV and never depends on byte_valid.
module imem_loader
    import imem_pkg::*;
#(
    parameter int pos      = POS,
    parameter int num_bits = NUM_BITS
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic [$clog2(pos):0]     len,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     we,
    output logic [$clog2(pos)-1:0]   waddr,
    output logic [num_bits-1:0]      wdata,
    output logic                     busy,
    output logic                     done,
    output loader_state_t            state
);

    localparam int AW = $clog2(pos);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] POS_L = LW'(pos);

    loader_state_t       state_n;
    logic [LW-1:0]       len_q;
    logic [LW-1:0]       wcnt;
    logic [LW-1:0]       wcnt_inc;
    logic [LW-1:0]       len_clamped;
    logic                fire;
    logic                load;
    logic                word_full;
    logic [num_bits-1:0] word_next;

    assign len_clamped = (len > POS_L) ? POS_L : len;
    assign wcnt_inc    = wcnt + LW'(1);
    assign load        = (state == IDLE) && start;
    assign fire        = byte_valid && byte_ready;

    byte_packer #(.num_bits(num_bits)) u_packer (
        .clk       (CLK),
        .rst       (RST),
        .clear     (load),
        .fire      (fire),
        .byte_data (byte_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = (len_clamped == '0) ? DONE : RECV;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_full) state_n = WRITE;
            end
            WRITE: begin
                we      = 1'b1;
                busy    = 1'b1;
                state_n = (wcnt_inc == len_q) ? DONE : RECV;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Length latch, word counter and registered write address/data.
    // The word counter stops at len_q (at most pos), so waddr never passes pos-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_q <= '0;
            wcnt  <= '0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            if (load) begin
                len_q <= len_clamped;
                wcnt  <= '0;
            end
            if (state == RECV && word_full) begin
                waddr <= wcnt[AW-1:0];
                wdata <= word_next;
            end
            if (state == WRITE) wcnt <= wcnt_inc;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader with a word-level reference model.
module tb_imem_loader;
    import imem_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [10:0]   len;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          we;
    logic [9:0]    waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    loader_state_t state;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [41:0] obs_q[$];
    logic [41:0] exp_q[$];
    logic [31:0] rom [0:1023];
    logic [7:0]  bytes_q[$];

    imem_loader dut (
        .CLK        (clk),
        .RST        (rst),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Write/done monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (we === 1'b1) begin
                obs_q.push_back({waddr, wdata});
                rom[waddr] = wdata;
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input int l);
        start = 1'b1;
        len   = 11'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        bit ok;
        k = 0;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!ok && k < 200) begin
            ok = (byte_ready === 1'b1);
            tick();
            k++;
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_timeout", 64'd0, 64'd1);
        repeat (gap) tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (state !== IDLE && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(state), 64'(IDLE));
    endtask

    // Reference: word i is bytes 4i..4i+3 little-endian at address i,
    // for i below min(len, 1024).
    task automatic model_load(input int l);
        int nw;
        nw = (l > 1024) ? 1024 : l;
        exp_q.delete();
        for (int i = 0; i < nw; i++)
            exp_q.push_back({10'(i), bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]});
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
    endtask

    task automatic random_bytes(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Full load with random inter-byte gaps up to maxgap.
    task automatic run_load(input string tag, input int l, input int maxgap);
        int d0;
        int nw;
        nw = (l > 1024) ? 1024 : l;
        d0 = done_cnt;
        model_load(l);
        start_load(l);
        for (int i = 0; i < 4*nw; i++) send_byte(bytes_q[i], $urandom_range(0, maxgap));
        wait_idle({tag, "_idle"}, 50);
        compare_writes(tag);
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (3) tick();

        // Reset state.
        check("rst_state", 64'(state), 64'(IDLE));
        check("rst_we", 64'(we), 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_ready", 64'(byte_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // Single word, back-to-back bytes, cycle-exact.
        bytes_q = '{8'h97, 8'h01, 8'h00, 8'h10};
        model_load(1);
        d0 = done_cnt;
        start_load(1);
        check("one_recv", 64'(state), 64'(RECV));
        check("one_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) send_byte(bytes_q[i], 0);
        check("one_we", 64'(we), 64'd1);
        check("one_waddr", 64'(waddr), 64'd0);
        check("one_wdata", 64'(wdata), 64'h10000197);
        check("one_ready_w", 64'(byte_ready), 64'd0);
        tick();
        check("one_done", 64'(done), 64'd1);
        check("one_busy_d", 64'(busy), 64'd0);
        check("one_we_off", 64'(we), 64'd0);
        check("one_hold", 64'(wdata), 64'h10000197);
        tick();
        check("one_idle", 64'(state), 64'(IDLE));
        check("one_done_off", 64'(done), 64'd0);
        compare_writes("one");
        check("one_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Four-word program and ROM readback.
        bytes_q = '{8'h97, 8'h01, 8'h00, 8'h10, 8'h83, 8'ha3, 8'h01, 8'h00,
                    8'h13, 8'h84, 8'h81, 8'h00, 8'h93, 8'h84, 8'h41, 8'h00};
        run_load("four", 4, 0);
        check("rom0", 64'(rom[0]), 64'h10000197);
        check("rom1", 64'(rom[1]), 64'h0001a383);
        check("rom2", 64'(rom[2]), 64'h00818413);
        check("rom3", 64'(rom[3]), 64'h00418493);

        // Stalls of 3 cycles between bytes.
        bytes_q = '{8'h97, 8'h01, 8'h00, 8'h10};
        run_load("stall", 1, 0);
        model_load(1);
        d0 = done_cnt;
        start_load(1);
        for (int i = 0; i < 4; i++) send_byte(bytes_q[i], 3);
        wait_idle("stall3_idle", 50);
        compare_writes("stall3");
        check("stall3_done", 64'(done_cnt - d0), 64'd1);

        // Randomized loads with random stalls.
        for (int t = 0; t < 4; t++) begin
            int l;
            l = $urandom_range(1, 9);
            random_bytes(4*l);
            run_load("rand", l, 2);
        end

        // len = 0: straight to DONE, no write.
        d0 = done_cnt;
        start_load(0);
        check("len0_state", 64'(state), 64'(DONE));
        check("len0_done", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        tick();
        check("len0_idle", 64'(state), 64'(IDLE));
        check("len0_writes", 64'(obs_q.size()), 64'd0);
        check("len0_done_cnt", 64'(done_cnt - d0), 64'd1);

        // len = 1025 clamps to 1024 writes ending at address 1023.
        random_bytes(4*1024);
        run_load("clamp", 1025, 0);
        check("clamp_last_addr", 64'(waddr), 64'd1023);

        // Reset mid-load after the first word.
        random_bytes(8);
        model_load(2);
        d0 = done_cnt;
        start_load(2);
        for (int i = 0; i < 6; i++) send_byte(bytes_q[i], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 64'(state), 64'(IDLE));
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(byte_ready), 64'd0);
        repeat (5) tick();
        check("midrst_done", 64'(done_cnt - d0), 64'd0);
        check("midrst_count", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0) check("midrst_write", 64'(obs_q[0]), 64'(exp_q[0]));
        obs_q.delete();
        random_bytes(4);
        run_load("after_rst", 1, 1);

        // Simultaneous reset and start: reset wins.
        rst = 1'b1; start = 1'b1; len = 11'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start", 64'(state), 64'(IDLE));
        tick();
        check("rst_start2", 64'(state), 64'(IDLE));

        // start while busy is ignored.
        random_bytes(20);
        model_load(5);
        d0 = done_cnt;
        start_load(5);
        send_byte(bytes_q[0], 0);
        send_byte(bytes_q[1], 0);
        start = 1'b1; len = 11'd1;
        tick();
        start = 1'b0;
        for (int i = 2; i < 20; i++) send_byte(bytes_q[i], $urandom_range(0, 1));
        wait_idle("busy_start_idle", 50);
        compare_writes("busy_start");
        check("busy_start_done", 64'(done_cnt - d0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
